// File: rtl/sw_run_sequencer.sv
// On-chip initiator for the FPGAWrapper command protocol: one go runs set_t, target load,
// then one scoring calculation per parameter-table entry, with a watchdog on every wait.
module sw_run_sequencer #(
    parameter int NUM_RUNS    = 2,
    parameter int PARAM_W     = 16,
    parameter int RESULT_W    = 16,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int AW         = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_go,
    input  logic                i_param_we,
    input  logic [AW-1:0]       i_param_addr,
    input  logic [PARAM_W-1:0]  i_param_data,
    input  logic                i_busy,
    input  logic                i_valid,
    input  logic [RESULT_W-1:0] i_result,
    output logic                o_set_t,
    output logic                o_start,
    output logic [PARAM_W-1:0]  o_param,
    output logic [RESULT_W-1:0] o_result,
    output logic [AW-1:0]       o_result_idx,
    output logic                o_result_valid,
    output logic                o_run_busy,
    output logic                o_done,
    output logic                o_error
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, SETT, GUARD, WAIT_T, LOAD, START, WAIT_V, WAIT_D, DONE, ERR
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [WD_W-1:0]       wd_q;
    logic [PARAM_W-1:0]    table_q [NUM_RUNS];

    logic                  set_t_q, start_q, rvalid_q, run_busy_q, done_q, error_q;
    logic [PARAM_W-1:0]    param_q;
    logic [RESULT_W-1:0]   result_q;
    logic [AW-1:0]         ridx_q;

    logic                  idle_like;
    logic                  in_wait;
    logic                  timeout;

    assign idle_like = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
    assign in_wait   = (state_q == WAIT_T) || (state_q == WAIT_V) || (state_q == WAIT_D);
    assign timeout   = (wd_q == WD_W'(TIMEOUT_CYC - 1));

    // Exit conditions are tested before the watchdog so a same-cycle exit always wins.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (i_go) begin
                    state_d = SETT;
                    idx_d   = '0;
                end
            end
            SETT:   state_d = GUARD;
            GUARD:  state_d = WAIT_T;
            WAIT_T: begin
                if (!i_busy)      state_d = LOAD;
                else if (timeout) state_d = ERR;
            end
            LOAD:   state_d = START;
            START:  state_d = WAIT_V;
            WAIT_V: begin
                if (i_valid)      state_d = WAIT_D;
                else if (timeout) state_d = ERR;
            end
            WAIT_D: begin
                if (!i_busy) begin
                    if (idx_q == AW'(NUM_RUNS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = LOAD;
                    end
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RUNS; i++) table_q[i] <= '0;
        end else if (i_param_we && idle_like && (32'(i_param_addr) < NUM_RUNS)) begin
            table_q[i_param_addr] <= i_param_data;
        end
    end

    // Outputs are decoded from the next state so every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wd_q       <= '0;
            set_t_q    <= 1'b0;
            start_q    <= 1'b0;
            param_q    <= '0;
            result_q   <= '0;
            ridx_q     <= '0;
            rvalid_q   <= 1'b0;
            run_busy_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_d != state_q) begin
                wd_q <= '0;
            end else if (in_wait) begin
                wd_q <= wd_q + WD_W'(1);
            end
            set_t_q    <= (state_d == SETT);
            start_q    <= (state_d == START);
            run_busy_q <= !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));
            done_q     <= (state_d == DONE);
            error_q    <= (state_d == ERR);
            // Loading on entry to LOAD gives the wrapper a full cycle of stable parameters before start.
            if (state_d == LOAD && state_q != LOAD) begin
                param_q <= table_q[idx_d];
            end
            rvalid_q <= 1'b0;
            if (state_q == WAIT_V && i_valid) begin
                result_q <= i_result;
                ridx_q   <= idx_q;
                rvalid_q <= 1'b1;
            end
        end
    end

    assign o_set_t        = set_t_q;
    assign o_start        = start_q;
    assign o_param        = param_q;
    assign o_result       = result_q;
    assign o_result_idx   = ridx_q;
    assign o_result_valid = rvalid_q;
    assign o_run_busy     = run_busy_q;
    assign o_done         = done_q;
    assign o_error        = error_q;

endmodule

// File: doc/sw_run_sequencer.md
Name: sw_run_sequencer

Overview:
- On-chip initiator for the FPGAWrapper command protocol, replacing the bench-driven sequence with hardware.
- On one go request it runs the full sequence on the wrapper:
  - pulses set_t, then waits for target load to finish;
  - for each entry of a small local scoring-parameter table, presents the parameters, pulses start, captures the result on valid, and waits for busy to fall.
- Sits between a host/config interface and FPGAWrapper. A watchdog flags a hung wrapper.

Parameters:
- NUM_RUNS, 2: parameter-table depth; number of calculations per go (≥1).
- PARAM_W, 16: scoring word width, packed {match[15:12], mismatch[11:8], minusAlpha[7:4], minusBeta[3:0]}.
- RESULT_W, 16: wrapper result width (instantiate with `V_E_F_Bit).
- TIMEOUT_CYC, 1000000: maximum cycles spent in any wait state before error.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst, input, 1: asynchronous, active-high reset.
- i_go, input, 1: start sequence; sampled in IDLE/DONE/ERR, ignored otherwise.
- i_param_we, input, 1: table write strobe; honoured only in IDLE/DONE/ERR.
- i_param_addr, input, max(1,$clog2(NUM_RUNS)): table write address; out-of-range writes are ignored.
- i_param_data, input, PARAM_W: table write data.
- i_busy, input, 1: wrapper o_busy.
- i_valid, input, 1: wrapper o_valid.
- i_result, input, RESULT_W: wrapper o_result.
- o_set_t, output, 1: to wrapper i_set_t.
- o_start, output, 1: to wrapper i_start_cal.
- o_param, output, PARAM_W: to wrapper match/mismatch/minusAlpha/minusBeta.
- o_result, output, RESULT_W: last captured result.
- o_result_idx, output, max(1,$clog2(NUM_RUNS)): table index of o_result.
- o_result_valid, output, 1: one-cycle pulse when a new result is captured.
- o_run_busy, output, 1: high in every state except IDLE/DONE/ERR.
- o_done, output, 1: sticky; all runs completed.
- o_error, output, 1: sticky; watchdog expired.

Behaviour:
- Reset (async, at any time, including mid-sequence):
  - state=IDLE; idx=0; watchdog=0; all table entries=0.
  - All outputs 0.
  - Deassertion takes effect on the next posedge.
- All outputs are registered; no combinational path from input to output.
- States and transitions:
  - IDLE/DONE/ERR: i_go → SETT; clears o_done, o_error and idx. A table write in the same cycle as i_go is still performed.
  - SETT: o_set_t=1 for exactly one cycle → GUARD.
  - GUARD: one cycle with o_set_t=0, giving the wrapper time to raise busy → WAIT_T.
  - WAIT_T: when i_busy==0 → LOAD.
  - LOAD: o_param<=table[idx] → START. o_param is stable ≥1 cycle before start and held unchanged until the next LOAD.
  - START: o_start=1 for exactly one cycle → WAIT_V.
  - WAIT_V: on i_valid==1 → WAIT_D. Captures o_result<=i_result and o_result_idx<=idx; o_result_valid=1 on the following cycle only.
  - WAIT_D: when i_busy==0:
    - idx==NUM_RUNS-1 → DONE (o_done=1);
    - otherwise idx+1 → LOAD.
- i_valid outside WAIT_V is ignored. A second valid within the same run does not recapture.
- o_set_t and o_start are never high simultaneously. Each is high for exactly one cycle per occurrence.
- Watchdog:
  - Counter is cleared on entry to every state and increments each cycle in WAIT_T/WAIT_V/WAIT_D.
  - Reaching TIMEOUT_CYC without the exit condition → ERR: o_error=1; o_run_busy=0; o_set_t/o_start=0.
  - If the exit condition and terminal count occur in the same cycle, the exit condition wins.
- i_go while o_run_busy=1 has no effect.
- o_result/o_result_idx hold until the next capture. They are not cleared by go.

Test Plan:
- NUM_RUNS=2; write table {16'h2111, 16'h3122}; go. Behavioural wrapper: busy high for 5 cycles after set_t, valid with result 16'd37 then 16'd52, busy falling 2 cycles after each valid. Required:
  - exactly one set_t pulse, then two start pulses;
  - o_param=2111 then 3122, each stable before its start;
  - o_result_valid pulses with (37, idx0) then (52, idx1);
  - o_done=1 and o_run_busy=0 at the end.
- Wrapper raises busy 1 cycle after set_t and drops it immediately → the GUARD cycle prevents a premature LOAD; the first start occurs only after busy has returned to 0.
- TIMEOUT_CYC=16, valid never asserted → ERR exactly 16 cycles after entering WAIT_V; o_error=1. A following i_go clears o_error and restarts with a set_t pulse.
- i_go and i_param_we pulsed mid-run → no restart; table unchanged (o_param for run 2 still 3122).
- Assert rst during WAIT_V → o_set_t/o_start/o_done/o_error/o_run_busy go to 0 immediately; table reads back 0 on the next run.
- Valid and watchdog terminal count in the same cycle → result captured, no error.
